// File: rtl/bcd_counter_ctrl_if.sv
// Board-side signal bundle for the BCD seconds counter controller: raw buttons,
// direction level, and the digit/status outputs feeding the 7-segment path.
interface bcd_counter_ctrl_if;
    logic       btn_start_stop;
    logic       btn_clear;
    logic       dir_down;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       tick;
    logic       terminal;

    modport master (
        output btn_start_stop, btn_clear, dir_down,
        input  tens, ones, running, tick, terminal
    );

    modport slave (
        input  btn_start_stop, btn_clear, dir_down,
        output tens, ones, running, tick, terminal
    );
endinterface

// File: rtl/bcd_counter_ctrl.sv
// Run/pause/clear controller for a two-digit BCD seconds counter with debounced buttons.
// Optional macro BCD_CTRL_STOP_AT_TERMINAL_EN: stop in DONE instead of wrapping.

module bcd_counter_ctrl_debounce #(
    parameter int unsigned CYCLES = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic press
);
    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic          level_dly_q;
    logic [CW-1:0] cnt_q;

    // Level flips only after CYCLES consecutive disagreeing samples; press marks the 0->1 edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            cnt_q       <= '0;
            press       <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], raw};
            level_dly_q <= level_q;
            press       <= level_q & ~level_dly_q;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end
endmodule

module bcd_counter_ctrl #(
    parameter int unsigned CLK_HZ          = 100_000_000,
    parameter int unsigned TICK_HZ         = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               reset_n,
    bcd_counter_ctrl_if.slave  bus
);
    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
`ifdef BCD_CTRL_STOP_AT_TERMINAL_EN
        , DONE = 2'd3
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    tens_q, tens_d, ones_q, ones_d;
    logic          tick_q, tick_d, terminal_q, terminal_d, running_q, running_d;
    logic          ss_evt, clr_evt, at_last, wrap;

    bcd_counter_ctrl_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_start_stop (
        .clk(clk), .reset_n(reset_n), .raw(bus.btn_start_stop), .press(ss_evt)
    );

    bcd_counter_ctrl_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk(clk), .reset_n(reset_n), .raw(bus.btn_clear), .press(clr_evt)
    );

    assign at_last = (state_q == RUN) && (presc_q == PRESC_LAST);
    assign wrap    = bus.dir_down ? ((tens_q == 4'd0) && (ones_q == 4'd0))
                                  : ((tens_q == 4'd9) && (ones_q == 4'd9));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Clear beats start_stop; a wrap in RUN overrides a coincident pause when stopping is enabled.
    always_comb begin
        state_d = state_q;
        if (clr_evt) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (ss_evt) state_d = RUN;
                RUN: begin
                    if (ss_evt) state_d = PAUSE;
`ifdef BCD_CTRL_STOP_AT_TERMINAL_EN
                    if (at_last && wrap) state_d = DONE;
`endif
                end
                PAUSE: if (ss_evt) state_d = RUN;
`ifdef BCD_CTRL_STOP_AT_TERMINAL_EN
                DONE:  state_d = DONE;
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        presc_d    = presc_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        tick_d     = 1'b0;
        terminal_d = 1'b0;
        running_d  = (state_d == RUN);
        if (clr_evt || (state_q == IDLE)) begin
            presc_d = '0;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
        end else if (state_q == RUN) begin
            if (at_last) begin
                presc_d    = '0;
                tick_d     = 1'b1;
                terminal_d = wrap;
                if (bus.dir_down) begin
                    if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = (tens_q == 4'd0) ? 4'd9 : tens_q - 4'd1;
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                end else begin
                    if (ones_q == 4'd9) begin
                        ones_d = 4'd0;
                        tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                end
`ifdef BCD_CTRL_STOP_AT_TERMINAL_EN
                if (wrap) begin
                    tens_d = tens_q;
                    ones_d = ones_q;
                end
`endif
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q    <= '0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            tick_q     <= 1'b0;
            terminal_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            tick_q     <= tick_d;
            terminal_q <= terminal_d;
            running_q  <= running_d;
        end
    end

    assign bus.tens     = tens_q;
    assign bus.ones     = ones_q;
    assign bus.tick     = tick_q;
    assign bus.terminal = terminal_q;
    assign bus.running  = running_q;
endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// Self-checking bench for bcd_counter_ctrl: tick scoreboard plus a table of count segments
// and hand-timed sequences for debounce, pause/resume, clear, coincidence and reset.
module tb_bcd_counter_ctrl;
    logic clk;
    logic reset_n;

    bcd_counter_ctrl_if bus();

    bcd_counter_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    typedef struct packed {
        logic [3:0] t;
        logic [3:0] o;
        logic       term;
    } exp_t;

    typedef struct {
        bit         dir;
        int         n;
        logic [7:0] bcd;
    } seg_t;

    exp_t sb[$];
    seg_t tbl [7];
    int   m;
    int   checks;
    int   failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Decimal model of the count; next value pushed to the scoreboard before its tick.
    task automatic push_next(input bit dir);
        int  nv;
        bit  term;
        if (!dir) begin
            term = (m == 99);
            nv   = term ? 0 : m + 1;
        end else begin
            term = (m == 0);
            nv   = term ? 99 : m - 1;
        end
`ifdef BCD_CTRL_STOP_AT_TERMINAL_EN
        if (term) nv = m;
`endif
        m = nv;
        sb.push_back('{t: 4'(m / 10), o: 4'(m % 10), term: term});
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 15 && !seen; i++) begin
            @(negedge clk);
            if (bus.tick === 1'b1) seen = 1'b1;
        end
        check("tick_seen", 32'(seen), 32'd1);
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.dir_down = tbl[i].dir;
            for (int k = 0; k < tbl[i].n; k++) begin
                push_next(tbl[i].dir);
                wait_tick();
            end
            check($sformatf("seg%0d_count", i), 32'({bus.tens, bus.ones}), 32'(tbl[i].bcd));
            check($sformatf("seg%0d_running", i), 32'(bus.running), 32'd1);
        end
    endtask

    task automatic press_clear_only();
        bus.btn_clear = 1'b1;
        cycles(8);
        check("clear_count", 32'({bus.tens, bus.ones}), 32'h00);
        check("clear_running", 32'(bus.running), 32'd0);
        cycles(2);
        bus.btn_clear = 1'b0;
        cycles(12);
        m = 0;
    endtask

    task automatic start_press();
        bus.btn_start_stop = 1'b1;
        cycles(10);
        bus.btn_start_stop = 1'b0;
    endtask

    // Every tick must match the head of the scoreboard; terminal never appears alone.
    always @(negedge clk) begin
        if (bus.tick === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_tick", 32'(bus.tick), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("tick_digits", 32'({bus.tens, bus.ones}), 32'({e.t, e.o}));
                check("tick_terminal", 32'(bus.terminal), 32'(e.term));
            end
        end else if (bus.terminal === 1'b1) begin
            check("terminal_without_tick", 32'(bus.terminal), 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit b [5];
        b = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        tbl[0] = '{dir: 1'b0, n: 15, bcd: 8'h25};
        tbl[1] = '{dir: 1'b0, n: 25, bcd: 8'h50};
        tbl[2] = '{dir: 1'b0, n: 25, bcd: 8'h75};
        tbl[3] = '{dir: 1'b0, n: 23, bcd: 8'h98};
        tbl[4] = '{dir: 1'b1, n: 10, bcd: 8'h89};
        tbl[5] = '{dir: 1'b0, n: 37, bcd: 8'h37};
        tbl[6] = '{dir: 1'b0, n: 40, bcd: 8'h40};

        checks = 0; failures = 0; m = 0;
        reset_n = 1'b0;
        bus.btn_start_stop = 1'b0;
        bus.btn_clear = 1'b0;
        bus.dir_down = 1'b0;
        cycles(3);
        check("reset_outputs", 32'({bus.tens, bus.ones, bus.running, bus.tick, bus.terminal}), 32'd0);
        reset_n = 1'b1;
        cycles(3);

        // Clean start press: running on the 8th edge, first tick 10 edges later.
        bus.btn_start_stop = 1'b1;
        cycles(7);
        check("start_running_early", 32'(bus.running), 32'd0);
        cycles(1);
        check("start_running", 32'(bus.running), 32'd1);
        cycles(2);
        bus.btn_start_stop = 1'b0;
        push_next(1'b0);
        cycles(7);
        check("first_tick_early", 32'(bus.tick), 32'd0);
        cycles(1);
        check("first_tick", 32'(bus.tick), 32'd1);
        for (int k = 0; k < 7; k++) begin
            push_next(1'b0);
            wait_tick();
        end

        // Pause at 08 with 8 prescale cycles already spent.
        bus.btn_start_stop = 1'b1;
        cycles(8);
        check("pause_running", 32'(bus.running), 32'd0);
        cycles(2);
        bus.btn_start_stop = 1'b0;
        cycles(40);
        check("pause_hold_count", 32'({bus.tens, bus.ones}), 32'h08);
        check("pause_hold_running", 32'(bus.running), 32'd0);

        // Bouncy resume: one event, 7 cycles after settling; tick after remaining 2 cycles.
        for (int i = 0; i < 5; i++) begin
            bus.btn_start_stop = b[i];
            cycles(1);
        end
        bus.btn_start_stop = 1'b1;
        push_next(1'b0);
        cycles(6);
        bus.btn_start_stop = 1'b0;
        cycles(1);
        check("bounce_running_early", 32'(bus.running), 32'd0);
        cycles(1);
        check("bounce_running", 32'(bus.running), 32'd1);
        cycles(1);
        check("resume_tick_early", 32'(bus.tick), 32'd0);
        cycles(1);
        check("resume_tick", 32'(bus.tick), 32'd1);
        push_next(1'b0);
        wait_tick();
        check("carry_count", 32'({bus.tens, bus.ones}), 32'h10);
        check("single_event_running", 32'(bus.running), 32'd1);

        run_table(0, 3);
        push_next(1'b0);
        wait_tick();
        push_next(1'b0);
        wait_tick();
`ifdef BCD_CTRL_STOP_AT_TERMINAL_EN
        check("done_up_count", 32'({bus.tens, bus.ones}), 32'h99);
        check("done_up_running", 32'(bus.running), 32'd0);
        start_press();
        cycles(20);
        check("done_ignore_ss_running", 32'(bus.running), 32'd0);
        check("done_ignore_ss_count", 32'({bus.tens, bus.ones}), 32'h99);
        press_clear_only();
        bus.dir_down = 1'b1;
        start_press();
        push_next(1'b1);
        wait_tick();
        check("done_down_count", 32'({bus.tens, bus.ones}), 32'h00);
        check("done_down_running", 32'(bus.running), 32'd0);
        press_clear_only();
`else
        check("wrap_up_count", 32'({bus.tens, bus.ones}), 32'h00);
        check("wrap_up_running", 32'(bus.running), 32'd1);
        bus.dir_down = 1'b1;
        push_next(1'b1);
        wait_tick();
        check("wrap_down_count", 32'({bus.tens, bus.ones}), 32'h99);
        run_table(4, 4);
        press_clear_only();
`endif
        bus.dir_down = 1'b0;
        start_press();
        run_table(5, 5);

        // Simultaneous clear and start_stop at 37: clear wins.
        bus.btn_start_stop = 1'b1;
        bus.btn_clear = 1'b1;
        cycles(7);
        check("both_pre_count", 32'({bus.tens, bus.ones}), 32'h37);
        cycles(1);
        check("both_count", 32'({bus.tens, bus.ones}), 32'h00);
        check("both_running", 32'(bus.running), 32'd0);
        cycles(2);
        bus.btn_start_stop = 1'b0;
        bus.btn_clear = 1'b0;
        cycles(20);
        check("both_idle_hold", 32'({bus.tens, bus.ones, bus.running}), 32'd0);
        m = 0;

        start_press();
        run_table(6, 6);

        // start_stop event on the terminal prescale: tick still happens, state goes to PAUSE.
        cycles(2);
        bus.btn_start_stop = 1'b1;
        push_next(1'b0);
        cycles(7);
        check("coinc_tick_early", 32'(bus.tick), 32'd0);
        cycles(1);
        check("coinc_tick", 32'(bus.tick), 32'd1);
        check("coinc_running", 32'(bus.running), 32'd0);
        cycles(2);
        bus.btn_start_stop = 1'b0;
        cycles(20);
        check("coinc_hold_count", 32'({bus.tens, bus.ones}), 32'h41);
        bus.btn_start_stop = 1'b1;
        push_next(1'b0);
        cycles(8);
        check("coinc_resume_running", 32'(bus.running), 32'd1);
        cycles(2);
        bus.btn_start_stop = 1'b0;
        cycles(7);
        check("full_interval_early", 32'(bus.tick), 32'd0);
        cycles(1);
        check("full_interval_tick", 32'(bus.tick), 32'd1);

        // Asynchronous reset mid-interval at 42.
        cycles(3);
        check("pre_reset_count", 32'({bus.tens, bus.ones}), 32'h42);
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({bus.tens, bus.ones, bus.running, bus.tick, bus.terminal}), 32'd0);
        cycles(3);
        check("held_reset_outputs", 32'({bus.tens, bus.ones, bus.running, bus.tick, bus.terminal}), 32'd0);
        reset_n = 1'b1;
        m = 0;
        cycles(15);
        check("post_reset_idle", 32'({bus.tens, bus.ones, bus.running}), 32'd0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
